// File: rtl/pipe_pkg.sv
// Shared definitions for the RISC pipeline stage registers: state encoding,
// default stage widths, control-bit positions and the kill-count helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stageState_e;

  localparam int EXMEM_DATA_W = 35;
  localparam int EXMEM_CTRL_W = 6;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BRANCH   = 5;

  // Number of beats destroyed by a flush: head not taken, skid entry, incoming beat.
  function automatic logic [1:0] killCount(input logic headKilled,
                                           input logic skidKilled,
                                           input logic inKilled);
    return {1'b0, headKilled} + {1'b0, skidKilled} + {1'b0, inKilled};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage, upstream and downstream sides.
interface pipe_stage_skid_if import pipe_pkg::*; #(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..3 increment; the sum is formed two bits wider and clamped.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] SAT_MAX = {W{1'b1}};

  logic [W-1:0] countR;
  logic [W-1:0] countNext;
  logic [W+1:0] sum;

  // Widened add and clamp to the all-ones ceiling.
  always_comb begin
    sum = {2'b00, countR} + {{W{1'b0}}, inc};
    if (sum > {2'b00, SAT_MAX}) begin
      countNext = SAT_MAX;
    end else begin
      countNext = sum[W-1:0];
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countR <= '0;
    end else if (en) begin
      countR <= countNext;
    end else begin
      countR <= countR;
    end
  end

  assign count = countR;
endmodule

// File: rtl/pipe_stage_skid.sv
// One pipeline stage with a 2-entry skid buffer: registered in_ready, FIFO order,
// synchronous flush to bubbles and a saturating count of killed beats.
module pipe_stage_skid import pipe_pkg::*; #(
  parameter int DATA_W              = EXMEM_DATA_W,
  parameter int CTRL_W              = EXMEM_CTRL_W,
  parameter int CLEAR_DATA_ON_FLUSH = 0,
  parameter int DROP_CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_stage_skid_if.slave      bus,
  input  logic                  flush,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  stageState_e       state, nState;
  logic              mainValid, nMainValid;
  logic [DATA_W-1:0] mainData, nMainData;
  logic [CTRL_W-1:0] mainCtrl, nMainCtrl;
  logic              skidValid, nSkidValid;
  logic [DATA_W-1:0] skidData, nSkidData;
  logic [CTRL_W-1:0] skidCtrl, nSkidCtrl;
  logic              inReadyR;
  logic              inFire, outFire;
  logic [1:0]        killInc;

  assign inFire  = bus.in_valid & inReadyR;
  assign outFire = mainValid & bus.out_ready;

  // Next-state and next-entry selection; flush overrides the handshake moves.
  always_comb begin
    nState     = state;
    nMainValid = mainValid;
    nMainData  = mainData;
    nMainCtrl  = mainCtrl;
    nSkidValid = skidValid;
    nSkidData  = skidData;
    nSkidCtrl  = skidCtrl;
    if (flush) begin
      nState     = ST_EMPTY;
      nMainValid = 1'b0;
      nSkidValid = 1'b0;
      nMainCtrl  = '0;
      nSkidCtrl  = '0;
      if (CLEAR_DATA_ON_FLUSH != 0) begin
        nMainData = '0;
        nSkidData = '0;
      end else begin
        nMainData = mainData;
        nSkidData = skidData;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (inFire) begin
            nState     = ST_FULL;
            nMainValid = 1'b1;
            nMainData  = bus.in_data;
            nMainCtrl  = bus.in_ctrl;
          end else begin
            nState = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (inFire && outFire) begin
            nMainData = bus.in_data;
            nMainCtrl = bus.in_ctrl;
          end else if (inFire) begin
            nState     = ST_SKID;
            nSkidValid = 1'b1;
            nSkidData  = bus.in_data;
            nSkidCtrl  = bus.in_ctrl;
          end else if (outFire) begin
            // Data is left in place; only valid and ctrl fall to the bubble value.
            nState     = ST_EMPTY;
            nMainValid = 1'b0;
            nMainCtrl  = '0;
          end else begin
            nState = ST_FULL;
          end
        end
        ST_SKID: begin
          if (outFire) begin
            nState     = ST_FULL;
            nMainData  = skidData;
            nMainCtrl  = skidCtrl;
            nSkidValid = 1'b0;
            nSkidCtrl  = '0;
          end else begin
            nState = ST_SKID;
          end
        end
        default: begin
          nState     = ST_EMPTY;
          nMainValid = 1'b0;
          nSkidValid = 1'b0;
          nMainCtrl  = '0;
          nSkidCtrl  = '0;
        end
      endcase
    end
  end

  // State, storage and registered in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      mainValid <= 1'b0;
      mainData  <= '0;
      mainCtrl  <= '0;
      skidValid <= 1'b0;
      skidData  <= '0;
      skidCtrl  <= '0;
      inReadyR  <= 1'b1;
    end else begin
      state     <= nState;
      mainValid <= nMainValid;
      mainData  <= nMainData;
      mainCtrl  <= nMainCtrl;
      skidValid <= nSkidValid;
      skidData  <= nSkidData;
      skidCtrl  <= nSkidCtrl;
      inReadyR  <= (nState != ST_SKID);
    end
  end

  assign killInc = killCount(mainValid & ~outFire, skidValid, inFire);

  sat_counter #(
    .W(DROP_CNT_W)
  ) u_dropCnt (
    .clk  (clk),
    .rst  (rst),
    .en   (flush),
    .inc  (killInc),
    .count(drop_cnt)
  );

  assign bus.in_ready  = inReadyR;
  assign bus.out_valid = mainValid;
  assign bus.out_data  = mainData;
  assign bus.out_ctrl  = mainCtrl;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (default, clear-on-flush, 2-bit counter)
// share one stimulus table; a FIFO scoreboard tracks surviving beats independently.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 35;
  localparam int CW = 6;
  localparam logic [CW-1:0] C_EVEN = 6'((1 << CTRL_BRANCH) | (1 << CTRL_REGWRITE));
  localparam logic [CW-1:0] C_ODD  = 6'((1 << CTRL_MEMREAD) | (1 << CTRL_MEMWRITE) | (1 << CTRL_ALUSRC));
  localparam logic [CW-1:0] C_LOAD = 6'((1 << CTRL_MEMREAD) | (1 << CTRL_MEMTOREG) | (1 << CTRL_REGWRITE));

  typedef struct {
    logic          inValid;
    logic [DW-1:0] inData;
    logic [CW-1:0] inCtrl;
    logic          outReady;
    logic          flush;
    logic          expValid;
    logic [DW-1:0] expData;
    logic [DW-1:0] expDataClr;
    logic [CW-1:0] expCtrl;
    logic          expReady;
    logic [7:0]    expDrop;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          inValid;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;
  logic          outReady;
  logic          flush;
  logic [7:0]    dropMain;
  logic [7:0]    dropClr;
  logic [1:0]    dropSmall;

  vec_t  vecs[$];
  beat_t sb[$];
  int    checks = 0;
  int    passes = 0;
  int    modelDrop = 0;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) busMain ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) busClr ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) busSmall ();

  assign busMain.in_valid   = inValid;
  assign busMain.in_data    = inData;
  assign busMain.in_ctrl    = inCtrl;
  assign busMain.out_ready  = outReady;
  assign busClr.in_valid    = inValid;
  assign busClr.in_data     = inData;
  assign busClr.in_ctrl     = inCtrl;
  assign busClr.out_ready   = outReady;
  assign busSmall.in_valid  = inValid;
  assign busSmall.in_data   = inData;
  assign busSmall.in_ctrl   = inCtrl;
  assign busSmall.out_ready = outReady;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA_ON_FLUSH(0), .DROP_CNT_W(8)) dutMain (
    .clk(clk), .rst(rst), .bus(busMain), .flush(flush), .drop_cnt(dropMain));
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA_ON_FLUSH(1), .DROP_CNT_W(8)) dutClr (
    .clk(clk), .rst(rst), .bus(busClr), .flush(flush), .drop_cnt(dropClr));
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA_ON_FLUSH(0), .DROP_CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst), .bus(busSmall), .flush(flush), .drop_cnt(dropSmall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addRow(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                        input logic orr, input logic fl, input logic ev, input logic [DW-1:0] ed,
                        input logic [DW-1:0] edc, input logic [CW-1:0] ec, input logic er,
                        input logic [7:0] edrop);
    vec_t v;
    v.inValid = iv; v.inData = id; v.inCtrl = ic; v.outReady = orr; v.flush = fl;
    v.expValid = ev; v.expData = ed; v.expDataClr = edc; v.expCtrl = ec;
    v.expReady = er; v.expDrop = edrop;
    vecs.push_back(v);
  endtask

  // Drive one row at the falling edge, score it, step one rising edge, compare.
  task automatic applyRow(input int idx);
    vec_t  v;
    beat_t b;
    bit    mReady;
    int    smallExp;
    v = vecs[idx];
    inValid = v.inValid; inData = v.inData; inCtrl = v.inCtrl;
    outReady = v.outReady; flush = v.flush;
    mReady = (sb.size() < 2);
    check($sformatf("sb_ready%0d", idx), 64'(busMain.in_ready), 64'(mReady));
    check($sformatf("sb_valid%0d", idx), 64'(busMain.out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0 && v.outReady) begin
      b = sb.pop_front();
      check($sformatf("sb_data%0d", idx), 64'(busMain.out_data), 64'(b.data));
      check($sformatf("sb_ctrl%0d", idx), 64'(busMain.out_ctrl), 64'(b.ctrl));
    end
    if (v.flush) begin
      modelDrop += sb.size() + ((v.inValid && mReady) ? 1 : 0);
      sb.delete();
    end else if (v.inValid && mReady) begin
      b.data = v.inData;
      b.ctrl = v.inCtrl;
      sb.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
    smallExp = (modelDrop > 3) ? 3 : modelDrop;
    check($sformatf("row%0d_valid", idx), 64'(busMain.out_valid), 64'(v.expValid));
    check($sformatf("row%0d_data", idx), 64'(busMain.out_data), 64'(v.expData));
    check($sformatf("row%0d_ctrl", idx), 64'(busMain.out_ctrl), 64'(v.expCtrl));
    check($sformatf("row%0d_ready", idx), 64'(busMain.in_ready), 64'(v.expReady));
    check($sformatf("row%0d_drop", idx), 64'(dropMain), 64'(v.expDrop));
    check($sformatf("row%0d_clrdata", idx), 64'(busClr.out_data), 64'(v.expDataClr));
    check($sformatf("row%0d_clrctrl", idx), 64'(busClr.out_ctrl), 64'(v.expCtrl));
    check($sformatf("row%0d_smalldrop", idx), 64'(dropSmall), 64'(v.expDrop > 8'd3 ? 8'd3 : v.expDrop));
    check($sformatf("row%0d_modeldrop", idx), 64'(dropSmall), 64'(smallExp));
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [CW-1:0] c;

    // Streaming at full rate, then drain.
    for (int i = 0; i < 8; i++) begin
      d = 35'h12345 + 35'(i);
      c = (i % 2 == 0) ? C_EVEN : C_ODD;
      addRow(1'b1, d, c, 1'b1, 1'b0, 1'b1, d, d, c, 1'b1, 8'd0);
    end
    addRow(1'b0, 35'h0, 6'h00, 1'b1, 1'b0, 1'b0, 35'h1234C, 35'h1234C, 6'h00, 1'b1, 8'd0);
    // Back-pressure fills the skid entry; a third offer is refused.
    addRow(1'b1, 35'h1, 6'h01, 1'b0, 1'b0, 1'b1, 35'h1, 35'h1, 6'h01, 1'b1, 8'd0);
    addRow(1'b1, 35'h2, 6'h02, 1'b0, 1'b0, 1'b1, 35'h1, 35'h1, 6'h01, 1'b0, 8'd0);
    addRow(1'b1, 35'h3, 6'h03, 1'b0, 1'b0, 1'b1, 35'h1, 35'h1, 6'h01, 1'b0, 8'd0);
    addRow(1'b0, 35'h0, 6'h00, 1'b1, 1'b0, 1'b1, 35'h2, 35'h2, 6'h02, 1'b1, 8'd0);
    addRow(1'b0, 35'h0, 6'h00, 1'b1, 1'b0, 1'b0, 35'h2, 35'h2, 6'h00, 1'b1, 8'd0);
    // Flush in SKID kills two beats.
    addRow(1'b1, 35'h1, 6'h01, 1'b0, 1'b0, 1'b1, 35'h1, 35'h1, 6'h01, 1'b1, 8'd0);
    addRow(1'b1, 35'h2, 6'h02, 1'b0, 1'b0, 1'b1, 35'h1, 35'h1, 6'h01, 1'b0, 8'd0);
    addRow(1'b0, 35'h0, 6'h00, 1'b0, 1'b1, 1'b0, 35'h1, 35'h0, 6'h00, 1'b1, 8'd2);
    // Flush while the head leaves: head not counted, incoming beat counted.
    addRow(1'b1, 35'h55, 6'h3F, 1'b0, 1'b0, 1'b1, 35'h55, 35'h55, 6'h3F, 1'b1, 8'd2);
    addRow(1'b1, 35'h66, C_LOAD, 1'b1, 1'b1, 1'b0, 35'h55, 35'h0, 6'h00, 1'b1, 8'd3);
    // More flushes push the 2-bit counter past its ceiling.
    addRow(1'b1, 35'h7, 6'h07, 1'b0, 1'b0, 1'b1, 35'h7, 35'h7, 6'h07, 1'b1, 8'd3);
    addRow(1'b1, 35'h8, 6'h08, 1'b0, 1'b0, 1'b1, 35'h7, 35'h7, 6'h07, 1'b0, 8'd3);
    addRow(1'b0, 35'h0, 6'h00, 1'b0, 1'b1, 1'b0, 35'h7, 35'h0, 6'h00, 1'b1, 8'd5);
    addRow(1'b1, 35'h9, 6'h09, 1'b0, 1'b1, 1'b0, 35'h7, 35'h0, 6'h00, 1'b1, 8'd6);
    addRow(1'b1, 35'hA, 6'h0A, 1'b1, 1'b0, 1'b1, 35'hA, 35'hA, 6'h0A, 1'b1, 8'd6);
    addRow(1'b0, 35'h0, 6'h00, 1'b1, 1'b0, 1'b0, 35'hA, 35'hA, 6'h00, 1'b1, 8'd6);
    // Refill to SKID ahead of the asynchronous reset.
    addRow(1'b1, 35'hB, 6'h0B, 1'b0, 1'b0, 1'b1, 35'hB, 35'hB, 6'h0B, 1'b1, 8'd6);
    addRow(1'b1, 35'hC, 6'h0C, 1'b0, 1'b0, 1'b1, 35'hB, 35'hB, 6'h0B, 1'b0, 8'd6);

    rst = 1'b1; inValid = 1'b0; inData = '0; inCtrl = '0; outReady = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 64'(busMain.out_valid), 64'd0);
    check("rst_data", 64'(busMain.out_data), 64'd0);
    check("rst_ctrl", 64'(busMain.out_ctrl), 64'd0);
    check("rst_ready", 64'(busMain.in_ready), 64'd1);
    check("rst_drop", 64'(dropMain), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyRow(i);
    end

    // Asynchronous reset between clock edges while holding two beats.
    inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(busMain.out_valid), 64'd0);
    check("arst_ctrl", 64'(busMain.out_ctrl), 64'd0);
    check("arst_data", 64'(busMain.out_data), 64'd0);
    check("arst_drop", 64'(dropMain), 64'd0);
    check("arst_ready", 64'(busMain.in_ready), 64'd1);
    sb.delete();
    modelDrop = 0;
    @(negedge clk);
    rst = 1'b0;
    inValid = 1'b1; inData = 35'h1D; inCtrl = C_LOAD; outReady = 1'b1;
    check("post_rst_empty", 64'(busMain.out_valid), 64'd0);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    check("post_rst_valid", 64'(busMain.out_valid), 64'd1);
    check("post_rst_data", 64'(busMain.out_data), 64'h1D);
    check("post_rst_ctrl", 64'(busMain.out_ctrl), 64'(C_LOAD));
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM-style stage register.
- Provides one pipeline stage with a valid/ready handshake on both sides and a 2-entry skid buffer, so back-pressure does not cause combinational ready paths.
- Synchronous flush turns held beats into bubbles. Saturating counter of killed beats for the hazard/perf logic.
- Instantiated between any two stages (ID/EX, EX/MEM, MEM/WB) of the RISC pipeline.

Parameters:
- DATA_W, 35, width of the datapath payload (e.g. alu_out 16 + regB 16 + rd 3).
- CTRL_W, 6, width of control bits (RegWrite, MemRead, MemWrite, MemToReg, ...); forced to 0 whenever the stage holds no valid beat.
- CLEAR_DATA_ON_FLUSH, 0, 1 = flush also zeroes stored data; 0 = data retained, only valid/ctrl cleared.
- DROP_CNT_W, 8, width of the saturating dropped-beat counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  beat present at output
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload of head entry
- out_ctrl  out  CTRL_W  control of head entry; 0 when out_valid=0
- flush  in  1  kill all held beats and any incoming beat this cycle
- drop_cnt  out  DROP_CNT_W  saturating count of killed beats

Behaviour:
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry, each holding valid, data, ctrl.
- States: EMPTY (no valid), FULL (main valid), SKID (main+skid valid).
- in_ready = (state != SKID), driven from a register. out_valid = main.valid.
- Transitions, when flush=0:
  - EMPTY: in_fire -> FULL, main <= in.
  - FULL: in_fire & out_fire -> FULL, main <= in.
  - FULL: in_fire & !out_fire -> SKID, skid <= in.
  - FULL: !in_fire & out_fire -> EMPTY.
  - FULL: otherwise hold.
  - SKID: out_fire -> FULL, main <= skid. in_fire is impossible in SKID.
- Latency and throughput:
  - Accepted beat is visible at out_valid on the next cycle (1-cycle latency).
  - Sustained 1 beat/cycle while out_ready=1.
  - Ordering is strictly FIFO.
- Data is held stable while out_valid=1 & out_ready=0.
- flush=1 (priority over everything except rst):
  - Next state EMPTY; main.valid and skid.valid <= 0; stored ctrl <= 0.
  - If CLEAR_DATA_ON_FLUSH=1, stored data <= 0; otherwise data is unchanged.
  - An in_fire in the same cycle is still consumed (in_ready was high) but discarded.
  - out_fire in the same cycle is honoured by the consumer; that beat does not count as dropped.
- drop_cnt:
  - On a flush cycle, add (main.valid & !out_fire) + skid.valid + in_fire.
  - Saturates at 2^DROP_CNT_W-1; never wraps.
  - Cleared only by rst.
- rst, asynchronous:
  - State EMPTY, all valids 0, data/ctrl 0, drop_cnt 0, in_ready 1.
  - Reset mid-transfer discards everything.
  - Outputs after reset: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
- Widths: DATA_W ≥ 1, CTRL_W ≥ 1. The counter add is performed at DROP_CNT_W+2 bits, then clamped.

Decomposition:
- Shared package pipe_pkg holds:
  - State enum ST_EMPTY / ST_FULL / ST_SKID.
  - Default widths for the RISC stages (EXMEM_DATA_W=35, EXMEM_CTRL_W=6).
  - Ctrl-bit index constants (CTRL_REGWRITE, CTRL_MEMREAD, ...).
- One natural sub-module: sat_counter (parametrised width, increment input 0..3, synchronous enable, async reset).

Test Plan:
1. Reset, then in_valid=1, in_data=0x1234_5, in_ctrl=6'b100001, out_ready=1 -> next cycle out_valid=1, out_data=0x12345, out_ctrl=6'b100001; stream of 8 beats emerges in order, 1/cycle.
2. out_ready=0 with two beats A=0x00001 then B=0x00002 offered -> state SKID, in_ready=0, out_data=A held; release out_ready -> A, then B on consecutive cycles, in_ready=1 after A leaves.
3. SKID state, flush=1, in_valid=0 -> next cycle out_valid=0, out_ctrl=0, drop_cnt=2. With CLEAR_DATA_ON_FLUSH=0, out_data still shows A; with 1, out_data=0.
4. FULL, out_ready=1, in_valid=1, flush=1 in the same cycle -> head beat consumed (not counted), incoming beat dropped, drop_cnt += 1, state EMPTY.
5. DROP_CNT_W=2: four flushes each killing 2 beats -> drop_cnt reaches 3 and stays at 3.
6. Assert rst asynchronously mid-stream while in SKID (between clock edges) -> out_valid, out_ctrl, drop_cnt drop to 0 immediately, in_ready=1; first beat after release appears with 1-cycle latency.
